cic_interp_ctrl: RTL and testbench
==================================

Name: cic_interp_ctrl

Overview:
Rate scheduler and input sequencer for the cic_interp datapath.
- Accepts an upstream I/Q stream (valid/ready) into a small FIFO and holds the current sample stable on the CIC input.
- Generates the CIC output-rate enable strobe from a phase accumulator.
- Advances to the next sample each time the CIC latches one.
- Runs a start/run/flush/idle state machine and flags starvation.

Parameters:
WIDTH, 16, I and Q sample width
FACTOR, 313, CIC interpolation factor (informational; used for status only)
STAGES, 5, CIC stage count; sets flush length
DELAY, 2, CIC differential delay; sets flush length
FIFO_DEPTH, 8, input FIFO entries; power of two, >= 2
PHASE_WIDTH, 24, phase accumulator width

Ports:
i_clock  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_start  in  1  single-cycle start request
i_stop  in  1  single-cycle stop request
i_phase_inc  in  PHASE_WIDTH  strobe rate; strobe frequency = f_clk*i_phase_inc/2^PHASE_WIDTH
i_inph  in  WIDTH  upstream in-phase sample
i_quad  in  WIDTH  upstream quadrature sample
i_valid  in  1  upstream sample valid
o_in_ready  out  1  FIFO can accept a sample
o_cic_inph  out  WIDTH  held in-phase sample to the CIC
o_cic_quad  out  WIDTH  held quadrature sample to the CIC
o_cic_ready  out  1  output-rate enable strobe to the CIC
i_cic_sample  in  1  CIC o_ready; high on the edge where the CIC latches the held sample
o_state  out  2  current state
o_fill  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
o_underflow  out  1  sticky starvation flag
i_clear_status  in  1  clears o_underflow

Behaviour:
Reset values:
- State IDLE; all outputs 0; FIFO empty; accumulator 0; flush counter 0.

IDLE (0):
- o_cic_ready=0; hold register=0; o_in_ready=0; accumulator held at 0.
- i_start -> PRIME. If i_start and i_stop are both high, stop wins and the block stays in IDLE.

PRIME (1):
- o_in_ready = !full.
- When FIFO is non-empty: pop into the hold register and go to RUN on the same edge.
- i_stop -> IDLE with the FIFO cleared.

RUN (2):
- Phase accumulator: acc <= acc + i_phase_inc, modulo 2^PHASE_WIDTH.
- o_cic_ready is the registered carry-out, one cycle wide.
- i_phase_inc=0 produces no strobes.
- On an edge with i_cic_sample=1: if FIFO is non-empty, pop into the hold register; otherwise load 0 into the hold register and set o_underflow.
- i_stop -> FLUSH on the next edge. A pop coincident with i_stop still completes.

FLUSH (3):
- o_in_ready=0; FIFO contents are discarded on entry.
- Hold register is forced to 0; strobes continue.
- Counts i_cic_sample pulses. At count STAGES*DELAY+1, go to IDLE and clear the accumulator.
- i_start is ignored.

FIFO:
- Push when i_valid && o_in_ready. Pop only as described above.
- A push and a pop on the same edge are both honoured; fill is unchanged.
- A pop on empty with a simultaneous push: the pop sees empty (underflow, hold=0) and the push is stored.
- o_fill is the registered occupancy.

Hold register:
- Changes only on pop or flush edges, so the CIC always samples a stable value.

o_underflow:
- Sticky. i_clear_status clears it, but a coincident set wins.

General:
- i_start outside IDLE is ignored.
- i_reset mid-operation aborts any state and returns to IDLE on the next edge.

Decomposition:
- Package cic_ctrl_pkg holds:
  - state_t enum {IDLE, PRIME, RUN, FLUSH} (2-bit)
  - function flush_len(STAGES, DELAY) = STAGES*DELAY+1
- Sub-module cic_ctrl_fifo: synchronous FIFO carrying {quad, inph}, with push/pop/clear, full/empty and fill outputs.

Test Plan:
- Reset, then i_start with FIFO empty -> stays PRIME, o_cic_ready=0. Push (100,-100) -> RUN; o_cic_inph=100, o_cic_quad=-100.
- PHASE_WIDTH=8, i_phase_inc=64 -> o_cic_ready high exactly one cycle in every 4; i_phase_inc=0 -> no strobes over 100 cycles.
- FIFO holds 3 samples, 5 i_cic_sample pulses -> hold register walks the 3 samples then 0,0; o_underflow=1 after the 4th pulse. i_clear_status -> 0.
- Upstream valid every cycle, CIC sampling slow -> o_fill saturates at 8, o_in_ready=0, no sample lost or duplicated (sequence counter check).
- i_stop in RUN with STAGES=5, DELAY=2 -> hold=0; IDLE after exactly 11 i_cic_sample pulses; i_start mid-FLUSH is ignored.
- i_reset asserted mid-RUN with FIFO at 5 -> next cycle state IDLE, o_fill=0, o_cic_ready=0, outputs 0.

Source files
------------

// File: rtl/cic_ctrl_pkg.sv
// rtl/cic_ctrl_pkg.sv - shared state encoding and flush-length helper for cic_interp_ctrl
package cic_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    // Output-rate pulses needed to push the last sample through the comb/integrator chain
    function automatic int flush_len(input int stages, input int delay);
        return stages * delay + 1;
    endfunction

endpackage

// File: rtl/cic_interp_ctrl_if.sv
// rtl/cic_interp_ctrl_if.sv - upstream I/Q sample stream with valid/ready handshake
interface cic_interp_ctrl_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] inph;
    logic [WIDTH-1:0] quad;
    logic             valid;
    logic             ready;

    modport master (output inph, output quad, output valid, input ready);
    modport slave  (input inph, input quad, input valid, output ready);
endinterface

// File: rtl/cic_ctrl_fifo.sv
// rtl/cic_ctrl_fifo.sv - synchronous FIFO with clear, full/empty and registered occupancy
module cic_ctrl_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_clear,
    input  logic                    i_push,
    input  logic                    i_pop,
    input  logic [DATA_WIDTH-1:0]   i_data,
    output logic [DATA_WIDTH-1:0]   o_data,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_fill
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_fill;

    wire w_push = i_push && !o_full;
    wire w_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clock) begin
        if (w_push)
            r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_fill <= r_fill + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = (r_fill == (AW+1)'(DEPTH));
    assign o_empty = (r_fill == '0);
    assign o_fill  = r_fill;
endmodule

// File: rtl/cic_interp_ctrl.sv
// rtl/cic_interp_ctrl.sv - rate scheduler and input sequencer feeding a CIC interpolator
module cic_interp_ctrl
    import cic_ctrl_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int FACTOR      = 313,
    parameter int STAGES      = 5,
    parameter int DELAY       = 2,
    parameter int FIFO_DEPTH  = 8,
    parameter int PHASE_WIDTH = 24
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_start,
    input  logic                        i_stop,
    input  logic [PHASE_WIDTH-1:0]      i_phase_inc,
    cic_interp_ctrl_if.slave            s_in,
    output logic [WIDTH-1:0]            o_cic_inph,
    output logic [WIDTH-1:0]            o_cic_quad,
    output logic                        o_cic_ready,
    input  logic                        i_cic_sample,
    output logic [1:0]                  o_state,
    output logic [$clog2(FIFO_DEPTH):0] o_fill,
    output logic                        o_underflow,
    input  logic                        i_clear_status
);
    localparam int FLUSH_LEN = flush_len(STAGES, DELAY);
    localparam int CW        = $clog2(FLUSH_LEN + 1);

    if (FACTOR < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
        $error("cic_interp_ctrl: invalid FACTOR or FIFO_DEPTH");
    end

    state_t                  r_state;
    logic [PHASE_WIDTH-1:0]  r_acc;
    logic                    r_strobe;
    logic [CW-1:0]           r_flush_cnt;
    logic [WIDTH-1:0]        r_hold_inph;
    logic [WIDTH-1:0]        r_hold_quad;
    logic                    r_underflow;

    logic                    w_full;
    logic                    w_empty;
    logic [2*WIDTH-1:0]      w_head;
    logic [$clog2(FIFO_DEPTH):0] w_fill;

    wire w_in_ready = (r_state == PRIME || r_state == RUN) && !w_full;
    wire w_push     = s_in.valid && w_in_ready;
    wire w_pop      = !w_empty && ((r_state == PRIME && !i_stop) || (r_state == RUN && i_cic_sample));
    wire w_clear    = (r_state == PRIME || r_state == RUN) && i_stop;
    wire w_starve   = (r_state == RUN) && i_cic_sample && w_empty;
    wire [PHASE_WIDTH:0] w_sum = {1'b0, r_acc} + {1'b0, i_phase_inc};

    cic_ctrl_fifo #(
        .DATA_WIDTH (2*WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_clear (w_clear),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({s_in.quad, s_in.inph}),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_fill  (w_fill)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_strobe    <= 1'b0;
            r_flush_cnt <= '0;
            r_hold_inph <= '0;
            r_hold_quad <= '0;
            r_underflow <= 1'b0;
        end else begin
            if (w_starve)
                r_underflow <= 1'b1;
            else if (i_clear_status)
                r_underflow <= 1'b0;

            case (r_state)
                IDLE: begin
                    r_acc       <= '0;
                    r_strobe    <= 1'b0;
                    r_flush_cnt <= '0;
                    r_hold_inph <= '0;
                    r_hold_quad <= '0;
                    if (i_start && !i_stop)
                        r_state <= PRIME;
                end
                PRIME: begin
                    if (i_stop) begin
                        r_state <= IDLE;
                    end else if (!w_empty) begin
                        {r_hold_quad, r_hold_inph} <= w_head;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_acc    <= w_sum[PHASE_WIDTH-1:0];
                    r_strobe <= w_sum[PHASE_WIDTH];
                    // An empty FIFO feeds zeros so the CIC never re-integrates a stale sample
                    if (i_cic_sample)
                        {r_hold_quad, r_hold_inph} <= w_empty ? '0 : w_head;
                    if (i_stop) begin
                        r_state     <= FLUSH;
                        r_flush_cnt <= '0;
                    end
                end
                FLUSH: begin
                    r_acc       <= w_sum[PHASE_WIDTH-1:0];
                    r_strobe    <= w_sum[PHASE_WIDTH];
                    r_hold_inph <= '0;
                    r_hold_quad <= '0;
                    if (i_cic_sample) begin
                        if (r_flush_cnt == CW'(FLUSH_LEN - 1)) begin
                            r_state     <= IDLE;
                            r_acc       <= '0;
                            r_strobe    <= 1'b0;
                            r_flush_cnt <= '0;
                        end else begin
                            r_flush_cnt <= r_flush_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s_in.ready  = w_in_ready;
    assign o_cic_inph  = r_hold_inph;
    assign o_cic_quad  = r_hold_quad;
    assign o_cic_ready = r_strobe;
    assign o_state     = r_state;
    assign o_fill      = w_fill;
    assign o_underflow = r_underflow;
endmodule

// File: tb/tb_cic_interp_ctrl.sv
// tb/tb_cic_interp_ctrl.sv - directed vector bench for cic_interp_ctrl
module tb_cic_interp_ctrl;
    localparam int W  = 16;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, stop, cic_sample, clr;
    logic [PW-1:0] phase_inc;
    logic [W-1:0]  cic_inph, cic_quad;
    logic          cic_ready, underflow;
    logic [1:0]    state;
    logic [3:0]    fill;

    int total = 0;
    int bad   = 0;

    cic_interp_ctrl_if #(.WIDTH(W)) u_if ();

    cic_interp_ctrl #(
        .WIDTH(W), .FACTOR(313), .STAGES(5), .DELAY(2), .FIFO_DEPTH(8), .PHASE_WIDTH(PW)
    ) dut (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_stop(stop),
        .i_phase_inc(phase_inc), .s_in(u_if),
        .o_cic_inph(cic_inph), .o_cic_quad(cic_quad), .o_cic_ready(cic_ready),
        .i_cic_sample(cic_sample), .o_state(state), .o_fill(fill),
        .o_underflow(underflow), .i_clear_status(clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         st, sp, v;
        logic [W-1:0] inph, quad;
        logic         s, c;
        logic [1:0]   e_state;
        logic [W-1:0] e_inph, e_quad;
        logic [3:0]   e_fill;
        logic         e_rdy, e_unf;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; stop = 0; cic_sample = 0; clr = 0;
        u_if.valid = 0; u_if.inph = '0; u_if.quad = '0;
    endtask

    logic [2*W-1:0] q [$];
    logic [2*W-1:0] exp_h;
    logic [W-1:0]   seq;
    bit             rdy_m;
    int             cnt, last, gap_bad;

    initial begin
        //           st sp v  inph    quad     s  c   es ei      eq       ef rdy unf
        vecs[0]  = '{0, 0, 0, 16'd0,  16'd0,   0, 0,  0, 16'd0,  16'd0,   0, 0, 0};
        vecs[1]  = '{0, 0, 1, 16'd5,  16'd5,   0, 0,  0, 16'd0,  16'd0,   0, 0, 0};
        vecs[2]  = '{1, 1, 0, 16'd0,  16'd0,   0, 0,  0, 16'd0,  16'd0,   0, 0, 0};
        vecs[3]  = '{1, 0, 0, 16'd0,  16'd0,   0, 0,  1, 16'd0,  16'd0,   0, 1, 0};
        vecs[4]  = '{0, 0, 0, 16'd0,  16'd0,   0, 0,  1, 16'd0,  16'd0,   0, 1, 0};
        vecs[5]  = '{0, 0, 1, 16'd100,-16'sd100,0, 0, 1, 16'd0,  16'd0,   1, 1, 0};
        vecs[6]  = '{0, 0, 0, 16'd0,  16'd0,   0, 0,  2, 16'd100,-16'sd100,0, 1, 0};
        vecs[7]  = '{0, 0, 1, 16'd7,  16'd8,   0, 0,  2, 16'd100,-16'sd100,1, 1, 0};
        vecs[8]  = '{0, 0, 1, 16'd9,  16'd10,  0, 0,  2, 16'd100,-16'sd100,2, 1, 0};
        vecs[9]  = '{0, 0, 0, 16'd0,  16'd0,   1, 0,  2, 16'd7,  16'd8,   1, 1, 0};
        vecs[10] = '{0, 0, 1, 16'd11, 16'd12,  1, 0,  2, 16'd9,  16'd10,  1, 1, 0};
        vecs[11] = '{0, 0, 0, 16'd0,  16'd0,   1, 0,  2, 16'd11, 16'd12,  0, 1, 0};
        vecs[12] = '{0, 0, 1, 16'd13, 16'd14,  1, 0,  2, 16'd0,  16'd0,   1, 1, 1};
        vecs[13] = '{0, 0, 0, 16'd0,  16'd0,   1, 1,  2, 16'd13, 16'd14,  0, 1, 0};
        vecs[14] = '{0, 0, 0, 16'd0,  16'd0,   1, 1,  2, 16'd0,  16'd0,   0, 1, 1};
        vecs[15] = '{0, 0, 0, 16'd0,  16'd0,   0, 1,  2, 16'd0,  16'd0,   0, 1, 0};
        vecs[16] = '{1, 0, 0, 16'd0,  16'd0,   0, 0,  2, 16'd0,  16'd0,   0, 1, 0};

        idle_inputs();
        phase_inc = '0;
        rst = 1;
        step();
        step();
        check("rst_state", state, 0);
        check("rst_fill", fill, 0);
        check("rst_out", {cic_inph, cic_quad, cic_ready, underflow, u_if.ready}, 0);
        rst = 0;

        for (int i = 0; i < 17; i++) begin
            start = vecs[i].st; stop = vecs[i].sp; u_if.valid = vecs[i].v;
            u_if.inph = vecs[i].inph; u_if.quad = vecs[i].quad;
            cic_sample = vecs[i].s; clr = vecs[i].c;
            step();
            check($sformatf("v%0d_state", i), state, vecs[i].e_state);
            check($sformatf("v%0d_hold", i), {cic_inph, cic_quad}, {vecs[i].e_inph, vecs[i].e_quad});
            check($sformatf("v%0d_fill", i), fill, vecs[i].e_fill);
            check($sformatf("v%0d_rdy", i), u_if.ready, vecs[i].e_rdy);
            check($sformatf("v%0d_unf", i), underflow, vecs[i].e_unf);
            check($sformatf("v%0d_strobe", i), cic_ready, 0);
        end
        idle_inputs();

        // strobe rate: inc=64 of 256 -> one pulse every 4 cycles
        phase_inc = 8'd64;
        cnt = 0; last = -1; gap_bad = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (cic_ready) begin
                if (last >= 0 && i - last != 4) gap_bad++;
                last = i;
                cnt++;
            end
        end
        check("strobe_count", cnt, 10);
        check("strobe_spacing", gap_bad, 0);
        phase_inc = '0;
        step();
        step();
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (cic_ready) cnt++;
        end
        check("zero_inc_strobes", cnt, 0);

        // saturation with sequence-numbered samples
        seq = 16'd1;
        q.delete();
        for (int i = 0; i < 42; i++) begin
            u_if.valid = 1; u_if.inph = seq; u_if.quad = ~seq;
            cic_sample = (i % 10 == 5);
            rdy_m = (q.size() < 8);
            check("sat_rdy", u_if.ready, rdy_m);
            if (cic_sample) exp_h = (q.size() > 0) ? q.pop_front() : '0;
            if (rdy_m) begin
                q.push_back({seq, ~seq});
                seq++;
            end
            step();
            check("sat_fill", fill, q.size());
            if (cic_sample) check("sat_hold", {cic_inph, cic_quad}, exp_h);
        end
        check("sat_full_fill", fill, 8);
        check("sat_full_rdy", u_if.ready, 0);
        u_if.valid = 0;
        for (int i = 0; i < 10; i++) begin
            cic_sample = 1;
            exp_h = (q.size() > 0) ? q.pop_front() : '0;
            step();
            check("drain_hold", {cic_inph, cic_quad}, exp_h);
        end
        check("drain_unf", underflow, 1);
        cic_sample = 0; clr = 1;
        step();
        check("drain_unf_clr", underflow, 0);
        idle_inputs();

        // flush: stop coincident with a pop, then 11 pulses with a stray start
        phase_inc = 8'd64;
        u_if.valid = 1; u_if.inph = 16'h55; u_if.quad = 16'h66;
        step();
        u_if.valid = 0; stop = 1; cic_sample = 1;
        step();
        check("flush_entry_state", state, 3);
        check("flush_entry_hold", {cic_inph, cic_quad}, {16'h55, 16'h66});
        check("flush_fill", fill, 0);
        check("flush_rdy", u_if.ready, 0);
        stop = 0; cic_sample = 0;
        step();
        check("flush_hold0", {cic_inph, cic_quad}, 0);
        cnt = 0;
        for (int p = 1; p <= 11; p++) begin
            cic_sample = 1;
            step();
            if (cic_ready) cnt++;
            check($sformatf("flush_p%0d", p), state, (p < 11) ? 2'd3 : 2'd0);
            cic_sample = 0; start = (p == 5);
            step();
            if (cic_ready && p < 11) cnt++;
            check($sformatf("flush_g%0d", p), state, (p < 11) ? 2'd3 : 2'd0);
            start = 0;
        end
        check("flush_strobes_seen", cnt > 0, 1);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (cic_ready) cnt++;
        end
        check("idle_no_strobe", cnt, 0);

        // reset mid-RUN with five samples queued
        start = 1;
        step();
        start = 0;
        for (int i = 0; i < 6; i++) begin
            u_if.valid = 1; u_if.inph = W'(i + 20); u_if.quad = W'(i + 40);
            step();
        end
        u_if.valid = 0;
        check("pre_rst_state", state, 2);
        check("pre_rst_fill", fill, 5);
        step();
        rst = 1;
        step();
        check("mid_rst_state", state, 0);
        check("mid_rst_fill", fill, 0);
        check("mid_rst_out", {cic_inph, cic_quad, cic_ready, underflow, u_if.ready}, 0);
        rst = 0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
